itcm_boot_loader: RTL and testbench

- Hardware boot loader between a byte-stream source (debug UART/bridge) and the ITCM write port.
- Holds the core in reset while loading.
- Packs incoming bytes little-endian into DATA_W-bit words and writes them from BASE_WORD upward.
- Releases the core once the programmed byte count has been written.
- Replaces bench-side byte-to-word preloading with a synthesizable, parametrised path.

---
 rtl/itcm_boot_loader_if.sv | 24 ++
 rtl/itcm_boot_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_itcm_boot_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/itcm_boot_loader_if.sv
// Byte-stream input and ITCM write port of the boot loader.
// master = loader side (drives the ITCM port), slave = stream source / memory side.
interface itcm_boot_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic                  byte_valid_i;
  logic [7:0]            byte_data_i;
  logic                  byte_ready_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wstrb_o;

  modport master (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport slave (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/itcm_boot_loader.sv
// Streams bytes into ITCM as little-endian words while holding the core in reset.
// Optional trailer checksum check enabled by defining ITCM_LOADER_CSUM_EN.
module itcm_boot_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_WORD = 0,
  parameter int unsigned LEN_W     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
  itcm_boot_loader_if.master bus,
  output logic               core_rst_n_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned     BYTES  = DATA_W / 8;
  localparam int unsigned     LANE_W = $clog2(BYTES);
  localparam longint unsigned DEPTH  = 64'(1) << ADDR_W;
  localparam longint unsigned CAP    = (DEPTH - 64'(BASE_WORD)) * 64'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]  wstrb_q, wstrb_d;
  logic              core_q, core_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [BYTES-1:0]  strb_q, strb_d;
`ifdef ITCM_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic hs, word_end, len_zero, len_over;

  assign hs       = bus.byte_valid_i & ready_q;
  assign word_end = (lane_q == LANE_W'(BYTES - 1)) || (rem_q == LEN_W'(1));
  assign len_zero = (len_i == '0);
  assign len_over = (64'(len_i) > CAP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          if (len_zero) begin
`ifdef ITCM_LOADER_CSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if (len_over) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  if (hs && word_end) state_d = S_WRITE;
      S_WRITE: begin
        if (rem_q != '0) begin
          state_d = S_LOAD;
        end else begin
`ifdef ITCM_LOADER_CSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ITCM_LOADER_CSUM_EN
      S_CHECK: if (hs) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of registered outputs and datapath
  always_comb begin
    ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = '0;
    wstrb_d = '0;
    core_d  = core_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    rem_d   = rem_q;
    word_d  = word_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    strb_d  = strb_q;
`ifdef ITCM_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          core_d = 1'b0;
          if (len_zero) begin
`ifdef ITCM_LOADER_CSUM_EN
            busy_d = 1'b1;
            sum_d  = '0;
`else
            done_d = 1'b1;
            core_d = 1'b1;
`endif
          end else if (len_over) begin
            err_d = 1'b1;
          end else begin
            rem_d  = len_i;
            word_d = ADDR_W'(BASE_WORD);
            lane_d = '0;
            buf_d  = '0;
            strb_d = '0;
            busy_d = 1'b1;
`ifdef ITCM_LOADER_CSUM_EN
            sum_d  = '0;
`endif
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          rem_d = rem_q - LEN_W'(1);
`ifdef ITCM_LOADER_CSUM_EN
          sum_d = sum_q + bus.byte_data_i;
`endif
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (lane_q == LANE_W'(i)) begin
              buf_d[8*i +: 8] = bus.byte_data_i;
              strb_d[i]       = 1'b1;
            end
          end
          // Word leaves on the output registers; pack buffer is freed at once
          if (word_end) begin
            we_d    = 1'b1;
            addr_d  = word_q;
            wdata_d = buf_d;
            wstrb_d = strb_d;
            buf_d   = '0;
            strb_d  = '0;
            lane_d  = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_WRITE: begin
        word_d = word_q + ADDR_W'(1);
`ifndef ITCM_LOADER_CSUM_EN
        if (rem_q == '0) begin
          done_d = 1'b1;
          core_d = 1'b1;
          busy_d = 1'b0;
        end
`endif
      end
`ifdef ITCM_LOADER_CSUM_EN
      S_CHECK: begin
        if (hs) begin
          busy_d = 1'b0;
          if (bus.byte_data_i == sum_q) begin
            done_d = 1'b1;
            core_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      core_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      strb_q  <= '0;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      core_q  <= core_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      strb_q  <= strb_d;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wstrb_o  = wstrb_q;
  assign core_rst_n_o     = core_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Scoreboard bench for itcm_boot_loader (DATA_W=32, ADDR_W=12, BASE_WORD=0).
// Expected ITCM writes are queued by the stimulus and popped by an independent monitor.
module tb_itcm_boot_loader;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [19:0] len_i;
  logic        core_rst_n_o, busy_o, done_o, err_o;

  itcm_boot_loader_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  itcm_boot_loader #(
    .DATA_W(32), .ADDR_W(12), .BASE_WORD(0), .LEN_W(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .bus          (bus),
    .core_rst_n_o (core_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  logic prev_we = 1'b0;

  logic [7:0] prog8 [8] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h23, 8'h00, 8'h20, 8'h00};
  int         gaps  [8] = '{3, 0, 5, 1, 2, 4, 0, 3};
  logic [7:0] rst4  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected word
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we_o) begin
      check("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, want no write",
                 bus.mem_addr_o, bus.mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr_o), 64'(e.addr));
        check("wr_data", 64'(bus.mem_wdata_o), 64'(e.data));
        check("wr_strb", 64'(bus.mem_wstrb_o), 64'(e.strb));
      end
    end
    prev_we <= bus.mem_we_o;
  end

  task automatic start_load(input logic [19:0] len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bus.byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    acc = 1'b0;
    for (int t = 0; t < 50; t++) begin
      acc = bus.byte_ready_o;
      @(negedge clk);
      if (acc) break;
    end
    bus.byte_valid_i = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_trailer(input logic [7:0] s);
`ifdef ITCM_LOADER_CSUM_EN
    send_byte(s, 0);
`else
    if (s == 8'hFF) @(negedge clk);
`endif
  endtask

  task automatic wait_end(input string nm, input logic d, input logic e, input logic c);
    for (int t = 0; t < 40; t++) begin
      if (!busy_o) break;
      @(negedge clk);
    end
    check({nm, "_busy"}, 64'(busy_o), 64'd0);
    check({nm, "_done"}, 64'(done_o), 64'(d));
    check({nm, "_err"},  64'(err_o),  64'(e));
    check({nm, "_core"}, 64'(core_rst_n_o), 64'(c));
    check({nm, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_core",  64'(core_rst_n_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_done",  64'(done_o), 64'd0);
    check("rst_err",   64'(err_o), 64'd0);
    check("rst_ready", 64'(bus.byte_ready_o), 64'd0);
    check("rst_we",    64'(bus.mem_we_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-byte program, back-to-back bytes
    exp_q.push_back('{12'h000, 32'h0050_0113, 4'hF});
    exp_q.push_back('{12'h001, 32'h0020_0023, 4'hF});
    start_load(20'd8);
    check("load8_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(prog8[i], 0);
    send_trailer(8'hA7);
    wait_end("load8", 1'b1, 1'b0, 1'b1);

    // 6 bytes: partial final word
    exp_q.push_back('{12'h000, 32'h0403_0201, 4'hF});
    exp_q.push_back('{12'h001, 32'h0000_0605, 4'h3});
    start_load(20'd6);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    send_trailer(8'h15);
    wait_end("load6", 1'b1, 1'b0, 1'b1);

    // 8-byte program with valid gaps
    exp_q.push_back('{12'h000, 32'h0050_0113, 4'hF});
    exp_q.push_back('{12'h001, 32'h0020_0023, 4'hF});
    start_load(20'd8);
    for (int i = 0; i < 8; i++) send_byte(prog8[i], gaps[i]);
    send_trailer(8'hA7);
    wait_end("gaps8", 1'b1, 1'b0, 1'b1);

    // Restart from DONE re-holds the core, then async reset mid-load
    start_load(20'd8);
    check("restart_core_held", 64'(core_rst_n_o), 64'd0);
    check("restart_done_clr",  64'(done_o), 64'd0);
    for (int i = 0; i < 3; i++) send_byte(prog8[i], 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_core",  64'(core_rst_n_o), 64'd0);
    check("midrst_busy",  64'(busy_o), 64'd0);
    check("midrst_ready", 64'(bus.byte_ready_o), 64'd0);
    check("midrst_addr",  64'(bus.mem_addr_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{12'h000, 32'hDDCC_BBAA, 4'hF});
    start_load(20'd4);
    for (int i = 0; i < 4; i++) send_byte(rst4[i], 0);
    send_trailer(8'h0E);
    wait_end("post_rst4", 1'b1, 1'b0, 1'b1);

    // Zero length
    start_load(20'd0);
`ifdef ITCM_LOADER_CSUM_EN
    send_trailer(8'h00);
    wait_end("len0", 1'b1, 1'b0, 1'b1);
`else
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_core", 64'(core_rst_n_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    check("len0_err",  64'(err_o), 64'd0);
`endif

    // Length one beyond capacity (4096 words * 4 bytes)
    start_load(20'd16385);
    check("over_err",  64'(err_o), 64'd1);
    check("over_done", 64'(done_o), 64'd0);
    check("over_core", 64'(core_rst_n_o), 64'd0);
    check("over_busy", 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk);
    check("over_ready", 64'(bus.byte_ready_o), 64'd0);

`ifdef ITCM_LOADER_CSUM_EN
    exp_q.push_back('{12'h000, 32'h0050_0113, 4'hF});
    start_load(20'd4);
    for (int i = 0; i < 4; i++) send_byte(prog8[i], 0);
    send_trailer(8'h64);
    wait_end("csum_ok", 1'b1, 1'b0, 1'b1);
    exp_q.push_back('{12'h000, 32'h0050_0113, 4'hF});
    start_load(20'd4);
    for (int i = 0; i < 4; i++) send_byte(prog8[i], 0);
    send_trailer(8'h65);
    wait_end("csum_bad", 1'b0, 1'b1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("final_pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
